// File: rtl/nbit_rr_mux.sv
// nbit_rr_mux: M-channel n-bit registered mux with fixed-select or round-robin arbitration
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   D, V, G     flattened channel data, per-channel valid, per-channel grant (combinational)
//   mode, S     0 = fixed select by S, 1 = round-robin
//   Y, Yv, Ych  registered output word, valid and source channel index
//   Yr          consumer ready
module nbit_rr_mux #(
    parameter int n  = 8,
    parameter int M  = 4,
    parameter int SW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [n*M-1:0]  D,
    input  logic [M-1:0]    V,
    output logic [M-1:0]    G,
    input  logic            mode,
    input  logic [SW-1:0]   S,
    output logic [n-1:0]    Y,
    output logic            Yv,
    output logic [SW-1:0]   Ych,
    input  logic            Yr
);
    logic          w_ld, w_win, w_vs, w_hi, w_lo;
    logic [SW-1:0] w_hidx, w_lidx, w_idx, r_ptr;
    logic [n-1:0]  w_d;
    // Cyclic search from ptr+1: the lowest valid channel above ptr wins, else the lowest valid overall.
    // Descending loops let the last (lowest) match overwrite earlier ones.
    always_comb begin
        w_ld   = !rst && (!Yv || Yr);
        w_vs   = 1'b0;
        w_hi   = 1'b0;
        w_lo   = 1'b0;
        w_hidx = '0;
        w_lidx = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (SW'(k) == S) w_vs = V[k];
            if (V[k] && SW'(k) > r_ptr) begin
                w_hi   = 1'b1;
                w_hidx = SW'(k);
            end
            if (V[k]) begin
                w_lo   = 1'b1;
                w_lidx = SW'(k);
            end
        end
        w_win = mode ? w_lo : w_vs;
        w_idx = mode ? (w_hi ? w_hidx : w_lidx) : S;
        w_d   = '0;
        G     = '0;
        for (int k = 0; k < M; k++) begin
            if (SW'(k) == w_idx) w_d = D[k*n +: n];
            G[k] = w_ld && w_win && (SW'(k) == w_idx);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            Y     <= '0;
            Yv    <= 1'b0;
            Ych   <= '0;
            r_ptr <= SW'(M - 1);
        end else if (w_ld) begin
            Yv <= w_win;
            if (w_win) begin
                Y     <= w_d;
                Ych   <= w_idx;
                r_ptr <= w_idx;
            end
        end
    end
endmodule

// File: tb/tb_nbit_rr_mux.sv
// tb_nbit_rr_mux: vector table, hand sequences and a model-driven scoreboard for nbit_rr_mux
module tb_nbit_rr_mux;
    typedef struct {
        logic       md;
        logic [1:0] s;
        logic [3:0] v;
        logic       yr;
        logic [3:0] g;
        logic [7:0] y;
        logic       yv;
        logic [1:0] ch;
    } vec_t;
    typedef struct {
        logic [7:0] y;
        logic       yv;
        logic [1:0] ch;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] D;
    logic [3:0]  V = '0;
    logic [3:0]  G;
    logic        mode = 1'b0;
    logic [1:0]  S = '0;
    logic [7:0]  Y;
    logic        Yv;
    logic [1:0]  Ych;
    logic        Yr = 1'b1;

    logic [23:0] D3;
    logic [2:0]  V3 = 3'b111;
    logic [2:0]  G3;
    logic [1:0]  S3 = 2'd0;
    logic [7:0]  Y3;
    logic        Yv3;
    logic [1:0]  Ych3;

    logic [7:0] dch [4];
    vec_t       tbl [$];
    out_t       q [$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         m_ptr;
    logic       m_yv;
    logic [7:0] m_y;
    logic [1:0] m_ch;

    always #5 clk = ~clk;

    nbit_rr_mux #(.n(8), .M(4), .SW(2)) dut (
        .clk(clk), .rst(rst), .D(D), .V(V), .G(G), .mode(mode), .S(S),
        .Y(Y), .Yv(Yv), .Ych(Ych), .Yr(Yr)
    );

    nbit_rr_mux #(.n(8), .M(3), .SW(2)) dut3 (
        .clk(clk), .rst(rst), .D(D3), .V(V3), .G(G3), .mode(1'b0), .S(S3),
        .Y(Y3), .Yv(Yv3), .Ych(Ych3), .Yr(1'b1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic md, input logic [1:0] s, input logic [3:0] v, input logic yr,
                       input logic [3:0] g, input logic [7:0] y, input logic yv, input logic [1:0] ch);
        vec_t r;
        r = '{md, s, v, yr, g, y, yv, ch};
        tbl.push_back(r);
    endtask

    task automatic run(input vec_t r);
        out_t e;
        mode = r.md;
        S    = r.s;
        V    = r.v;
        Yr   = r.yr;
        q.push_back('{r.y, r.yv, r.ch});
        @(negedge clk);
        chk("G", 32'(G), 32'(r.g));
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("Y", 32'(Y), 32'(e.y));
        chk("Yv", 32'(Yv), 32'(e.yv));
        chk("Ych", 32'(Ych), 32'(e.ch));
    endtask

    task automatic hand(input logic md, input logic [1:0] s, input logic [3:0] v, input logic yr,
                        input logic [3:0] g, input logic [7:0] y, input logic yv, input logic [1:0] ch);
        run('{md, s, v, yr, g, y, yv, ch});
    endtask

    // Reference: ordered cyclic scan ptr+1, ptr+2, ... modulo 4.
    task automatic model(input logic md, input logic [1:0] s, input logic [3:0] v, input logic yr);
        logic       ld, found;
        logic [1:0] w, c;
        logic [3:0] g;
        ld    = !m_yv || yr;
        found = 1'b0;
        w     = '0;
        if (!md) begin
            found = v[s];
            w     = s;
        end else begin
            for (int off = 1; off <= 4; off++) begin
                c = 2'((m_ptr + off) % 4);
                if (!found && v[c]) begin
                    found = 1'b1;
                    w     = c;
                end
            end
        end
        g = (ld && found) ? (4'b0001 << w) : 4'b0000;
        if (ld) begin
            m_yv = found;
            if (found) begin
                m_y   = dch[w];
                m_ch  = w;
                m_ptr = int'(w);
            end
        end
        run('{md, s, v, yr, g, m_y, m_yv, m_ch});
    endtask

    initial begin
        dch = '{8'h03, 8'h0C, 8'h30, 8'hC0};
        D   = {dch[3], dch[2], dch[1], dch[0]};
        D3  = {8'h30, 8'h0C, 8'h03};
        // fixed select S=0..3
        add(0, 0, 4'hF, 1, 4'h1, 8'h03, 1, 0);
        add(0, 1, 4'hF, 1, 4'h2, 8'h0C, 1, 1);
        add(0, 2, 4'hF, 1, 4'h4, 8'h30, 1, 2);
        add(0, 3, 4'hF, 1, 4'h8, 8'hC0, 1, 3);
        // round robin, all valid, wraps 3 -> 0
        add(1, 0, 4'hF, 1, 4'h1, 8'h03, 1, 0);
        add(1, 0, 4'hF, 1, 4'h2, 8'h0C, 1, 1);
        add(1, 0, 4'hF, 1, 4'h4, 8'h30, 1, 2);
        add(1, 0, 4'hF, 1, 4'h8, 8'hC0, 1, 3);
        add(1, 0, 4'hF, 1, 4'h1, 8'h03, 1, 0);
        add(1, 0, 4'hF, 1, 4'h2, 8'h0C, 1, 1);
        // sparse V=1010
        add(1, 0, 4'hA, 1, 4'h8, 8'hC0, 1, 3);
        add(1, 0, 4'hA, 1, 4'h2, 8'h0C, 1, 1);
        add(1, 0, 4'hA, 1, 4'h8, 8'hC0, 1, 3);
        add(1, 0, 4'hA, 1, 4'h2, 8'h0C, 1, 1);
        // backpressure
        add(1, 0, 4'hF, 0, 4'h0, 8'h0C, 1, 1);
        add(1, 0, 4'hF, 0, 4'h0, 8'h0C, 1, 1);
        add(1, 0, 4'hF, 0, 4'h0, 8'h0C, 1, 1);
        add(1, 0, 4'hF, 1, 4'h4, 8'h30, 1, 2);
        // no winner, then empty output loads despite Yr=0
        add(1, 0, 4'h0, 1, 4'h0, 8'h30, 0, 2);
        add(1, 0, 4'h0, 0, 4'h0, 8'h30, 0, 2);
        add(1, 0, 4'h1, 0, 4'h1, 8'h03, 1, 0);
        add(1, 0, 4'h1, 0, 4'h0, 8'h03, 1, 0);
        // fixed select of an idle channel, then pointer handoff into round robin
        add(0, 2, 4'h1, 1, 4'h0, 8'h03, 0, 0);
        add(0, 0, 4'h1, 1, 4'h1, 8'h03, 1, 0);
        add(1, 0, 4'hF, 1, 4'h2, 8'h0C, 1, 1);

        V    = 4'hF;
        mode = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("G_in_reset", 32'(G), 32'h0);
        chk("Y_reset", 32'(Y), 32'h0);
        chk("Yv_reset", 32'(Yv), 32'h0);
        chk("Ych_reset", 32'(Ych), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i]);

        // stall after first load, release, stall again, reset mid-stall
        rst = 1'b1;
        hand(1, 0, 4'hF, 1, 4'h0, 8'h00, 0, 0);
        rst = 1'b0;
        hand(1, 0, 4'hF, 0, 4'h1, 8'h03, 1, 0);
        hand(1, 0, 4'hF, 0, 4'h0, 8'h03, 1, 0);
        hand(1, 0, 4'hF, 0, 4'h0, 8'h03, 1, 0);
        hand(1, 0, 4'hF, 0, 4'h0, 8'h03, 1, 0);
        hand(1, 0, 4'hF, 1, 4'h2, 8'h0C, 1, 1);
        hand(1, 0, 4'hF, 0, 4'h0, 8'h0C, 1, 1);
        rst = 1'b1;
        hand(1, 0, 4'hF, 0, 4'h0, 8'h00, 0, 0);
        rst = 1'b0;
        hand(1, 0, 4'hF, 1, 4'h1, 8'h03, 1, 0);

        // M=3: S=0 has been selected all along, then S=3 never grants
        chk("m3_Yv_s0", 32'(Yv3), 32'h1);
        chk("m3_Y_s0", 32'(Y3), 32'h03);
        S3 = 2'd3;
        @(negedge clk);
        chk("m3_G_s3", 32'(G3), 32'h0);
        @(posedge clk);
        #1;
        chk("m3_Yv_s3", 32'(Yv3), 32'h0);
        chk("m3_Y_hold", 32'(Y3), 32'h03);

        // random traffic against the reference scan
        rst = 1'b1;
        hand(0, 0, 4'h0, 1, 4'h0, 8'h00, 0, 0);
        rst   = 1'b0;
        m_ptr = 3;
        m_yv  = 1'b0;
        m_y   = '0;
        m_ch  = '0;
        for (int i = 0; i < 300; i++)
            model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0));

        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
